// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU and the EX/MEM register.
// Define MUL_EN to enable the iterative shift-add multiplier (op 9).
module ex_stage #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PR2_valid,
  input  logic [WORD_WIDTH-1:0] PR2_data_rs,
  input  logic [WORD_WIDTH-1:0] PR2_data_rt,
  input  logic [WORD_WIDTH-1:0] PR2_imm,
  input  logic                  PR2_alu_src,
  input  logic [3:0]            PR2_alu_op,
  input  logic [2:0]            PR2_rd,
  input  logic                  PR2_RF_write_en,
  input  logic                  PR2_MEM_read,
  input  logic                  PR2_MEM_write,
  input  logic [1:0]            forwardA,
  input  logic [1:0]            forwardB,
  input  logic [WORD_WIDTH-1:0] PR4_wb_data,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  ex_busy,
  output logic                  PR3_valid,
  output logic [WORD_WIDTH-1:0] PR3_alu_result,
  output logic [WORD_WIDTH-1:0] PR3_store_data,
  output logic                  PR3_zero,
  output logic [2:0]            PR3_rd,
  output logic                  PR3_RF_write_en,
  output logic                  PR3_MEM_read,
  output logic                  PR3_MEM_write
);
  localparam int W = WORD_WIDTH;

  typedef struct packed {
    logic         valid;
    logic [W-1:0] alu_result;
    logic [W-1:0] store_data;
    logic         zero;
    logic [2:0]   rd;
    logic         rf_we;
    logic         mem_rd;
    logic         mem_wr;
  } pr3_t;

  typedef enum logic [1:0] {
    LD_HOLD, LD_BUBBLE, LD_ALU, LD_MUL
  } ld_t;

  pr3_t         pr3_q, pr3_d;
  ld_t          ld;
  logic [W-1:0] op_a, op_b, rt_fwd, alu_y;
  logic [W-1:0] mul_y, mul_st;
  logic         is_mul;

  assign is_mul = PR2_alu_op == 4'd9;

  always_comb begin
    case (forwardA)
      2'd1:    op_a = PR4_wb_data;
      2'd2:    op_a = pr3_q.alu_result;
      default: op_a = PR2_data_rs;
    endcase
    case (forwardB)
      2'd1:    rt_fwd = PR4_wb_data;
      2'd2:    rt_fwd = pr3_q.alu_result;
      default: rt_fwd = PR2_data_rt;
    endcase
    op_b = PR2_alu_src ? PR2_imm : rt_fwd;
  end

  always_comb begin
    alu_y = '0;
    case (PR2_alu_op)
      4'd0: alu_y = op_a + op_b;
      4'd1: alu_y = op_a - op_b;
      4'd2: alu_y = op_a & op_b;
      4'd3: alu_y = op_a | op_b;
      4'd4: alu_y = op_a ^ op_b;
      4'd5: alu_y = op_a << op_b[2:0];
      4'd6: alu_y = op_a >> op_b[2:0];
      4'd7: alu_y = {{(W-1){1'b0}},
                     $signed(op_a) < $signed(op_b)};
      4'd8: alu_y = op_b;
      default: alu_y = '0;
    endcase
  end

`ifdef MUL_EN
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [2:0] LAST = 3'(W - 1);

  state_t       state_q, state_d;
  logic [2:0]   cnt_q;
  logic [W-1:0] acc_q, mul_a_q, mul_b_q, mul_st_q, pp;
  logic         last, accept;

  assign last   = cnt_q == LAST;
  assign accept = (state_q == IDLE) & PR2_valid & is_mul;
  assign pp     = mul_b_q[cnt_q] ? (mul_a_q << cnt_q) : '0;
  assign mul_y  = acc_q + pp;
  assign mul_st = mul_st_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) state_d = IDLE;
    else if (!stall) begin
      unique case (state_q)
        IDLE:    if (accept) state_d = BUSY;
        BUSY:    if (last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // operands are captured once; rt is kept for the store-data field
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      mul_st_q <= '0;
    end else if (!flush && !stall) begin
      if (accept) begin
        cnt_q    <= '0;
        acc_q    <= '0;
        mul_a_q  <= op_a;
        mul_b_q  <= op_b;
        mul_st_q <= rt_fwd;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + 3'd1;
        acc_q <= mul_y;
      end
    end
  end

  always_comb begin
    ex_busy = accept | ((state_q == BUSY) & ~last);
    ld      = LD_ALU;
    if (flush)                  ld = LD_BUBBLE;
    else if (stall)             ld = LD_HOLD;
    else if (state_q == BUSY)   ld = last ? LD_MUL : LD_BUBBLE;
    else if (!PR2_valid || is_mul) ld = LD_BUBBLE;
  end
`else
  assign ex_busy = 1'b0;
  assign mul_y   = '0;
  assign mul_st  = '0;

  always_comb begin
    ld = LD_ALU;
    if (flush)           ld = LD_BUBBLE;
    else if (stall)      ld = LD_HOLD;
    else if (!PR2_valid) ld = LD_BUBBLE;
  end
`endif

  always_comb begin
    pr3_d = pr3_q;
    case (ld)
      LD_BUBBLE: pr3_d = '0;
      LD_ALU: pr3_d = '{valid: 1'b1,
                        alu_result: alu_y,
                        store_data: rt_fwd,
                        zero: alu_y == '0,
                        rd: PR2_rd,
                        rf_we: PR2_RF_write_en,
                        mem_rd: PR2_MEM_read,
                        mem_wr: PR2_MEM_write};
      LD_MUL: pr3_d = '{valid: 1'b1,
                        alu_result: mul_y,
                        store_data: mul_st,
                        zero: mul_y == '0,
                        rd: PR2_rd,
                        rf_we: PR2_RF_write_en,
                        mem_rd: PR2_MEM_read,
                        mem_wr: PR2_MEM_write};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pr3_q <= '0;
    else        pr3_q <= pr3_d;
  end

  assign PR3_valid       = pr3_q.valid;
  assign PR3_alu_result  = pr3_q.alu_result;
  assign PR3_store_data  = pr3_q.store_data;
  assign PR3_zero        = pr3_q.zero;
  assign PR3_rd          = pr3_q.rd;
  assign PR3_RF_write_en = pr3_q.rf_we;
  assign PR3_MEM_read    = pr3_q.mem_rd;
  assign PR3_MEM_write   = pr3_q.mem_wr;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases plus random traffic
// checked against a transaction-level model.
module tb_ex_stage;
  localparam int W = 8;
`ifdef MUL_EN
  localparam bit MUL = 1'b1;
`else
  localparam bit MUL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         PR2_valid = 1'b0;
  logic [W-1:0] PR2_data_rs = '0;
  logic [W-1:0] PR2_data_rt = '0;
  logic [W-1:0] PR2_imm = '0;
  logic         PR2_alu_src = 1'b0;
  logic [3:0]   PR2_alu_op = '0;
  logic [2:0]   PR2_rd = '0;
  logic         PR2_RF_write_en = 1'b0;
  logic         PR2_MEM_read = 1'b0;
  logic         PR2_MEM_write = 1'b0;
  logic [1:0]   forwardA = '0;
  logic [1:0]   forwardB = '0;
  logic [W-1:0] PR4_wb_data = '0;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic         ex_busy, PR3_valid, PR3_zero;
  logic [W-1:0] PR3_alu_result, PR3_store_data;
  logic [2:0]   PR3_rd;
  logic         PR3_RF_write_en, PR3_MEM_read;
  logic         PR3_MEM_write;

  always #5 clk = ~clk;

  ex_stage #(.WORD_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .PR2_valid(PR2_valid),
    .PR2_data_rs(PR2_data_rs),
    .PR2_data_rt(PR2_data_rt),
    .PR2_imm(PR2_imm),
    .PR2_alu_src(PR2_alu_src),
    .PR2_alu_op(PR2_alu_op),
    .PR2_rd(PR2_rd),
    .PR2_RF_write_en(PR2_RF_write_en),
    .PR2_MEM_read(PR2_MEM_read),
    .PR2_MEM_write(PR2_MEM_write),
    .forwardA(forwardA), .forwardB(forwardB),
    .PR4_wb_data(PR4_wb_data),
    .stall(stall), .flush(flush),
    .ex_busy(ex_busy),
    .PR3_valid(PR3_valid),
    .PR3_alu_result(PR3_alu_result),
    .PR3_store_data(PR3_store_data),
    .PR3_zero(PR3_zero),
    .PR3_rd(PR3_rd),
    .PR3_RF_write_en(PR3_RF_write_en),
    .PR3_MEM_read(PR3_MEM_read),
    .PR3_MEM_write(PR3_MEM_write)
  );

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // transaction-level model of the EX/MEM register
  typedef struct packed {
    logic v;
    logic [W-1:0] r;
    logic [W-1:0] s;
    logic z;
    logic [2:0] rd;
    logic w, mr, mw;
  } p3_t;

  p3_t          m_p3 = '0;
  bit           m_busy = 1'b0;
  int           m_left = 0;
  logic [W-1:0] m_mul = '0;
  logic [W-1:0] m_mst = '0;

  function automatic logic [W-1:0] fv(
    input logic [1:0] sel, input logic [W-1:0] reg_v);
    if (sel == 2'd1) return PR4_wb_data;
    if (sel == 2'd2) return m_p3.r;
    return reg_v;
  endfunction

  function automatic logic [W-1:0] alu(
    input logic [3:0] op,
    input logic [W-1:0] a, input logic [W-1:0] b);
    int sh;
    sh = int'(b) % 8;
    case (op)
      4'd0: return W'(a + b);
      4'd1: return W'(a - b);
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return W'(a << sh);
      4'd6: return a >> sh;
      4'd7: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd8: return b;
      4'd9: return MUL ? W'(a * b) : '0;
      default: return '0;
    endcase
  endfunction

  function automatic bit exp_busy();
    if (!MUL) return 1'b0;
    if (m_busy) return m_left > 1;
    return PR2_valid && PR2_alu_op == 4'd9;
  endfunction

  function automatic p3_t entry(input logic [W-1:0] r,
                                input logic [W-1:0] s);
    return '{v: 1'b1, r: r, s: s, z: r == '0,
             rd: PR2_rd, w: PR2_RF_write_en,
             mr: PR2_MEM_read, mw: PR2_MEM_write};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] a, rt, b;
    a  = fv(forwardA, PR2_data_rs);
    rt = fv(forwardB, PR2_data_rt);
    b  = PR2_alu_src ? PR2_imm : rt;
    if (!rst_n) begin
      m_p3 <= '0; m_busy <= 1'b0; m_left <= 0;
    end else if (flush) begin
      m_p3 <= '0; m_busy <= 1'b0;
    end else if (stall) begin
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_p3 <= entry(m_mul, m_mst);
        m_busy <= 1'b0;
      end else begin
        m_p3 <= '0;
        m_left <= m_left - 1;
      end
    end else if (!PR2_valid) begin
      m_p3 <= '0;
    end else if (MUL && PR2_alu_op == 4'd9) begin
      m_busy <= 1'b1;
      m_left <= W;
      m_mul  <= W'(a * b);
      m_mst  <= rt;
      m_p3   <= '0;
    end else begin
      m_p3 <= entry(alu(PR2_alu_op, a, b), rt);
    end
  end

  always @(negedge clk) begin
    if (run && rst_n) begin
      check("valid", PR3_valid, m_p3.v);
      check("result", PR3_alu_result, m_p3.r);
      check("store", PR3_store_data, m_p3.s);
      check("zero", PR3_zero, m_p3.z);
      check("rd", PR3_rd, m_p3.rd);
      check("rf_we", PR3_RF_write_en, m_p3.w);
      check("mem_rd", PR3_MEM_read, m_p3.mr);
      check("mem_wr", PR3_MEM_write, m_p3.mw);
      check("busy", ex_busy, exp_busy());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic instr(input logic [3:0] op,
                       input logic [W-1:0] rs,
                       input logic [W-1:0] rt);
    PR2_valid = 1'b1; PR2_alu_op = op;
    PR2_data_rs = rs; PR2_data_rt = rt;
    PR2_alu_src = 1'b0; PR2_rd = 3'd3;
    PR2_RF_write_en = 1'b1;
    PR2_MEM_read = 1'b0; PR2_MEM_write = 1'b0;
    forwardA = 2'd0; forwardB = 2'd0;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, PR3_valid, 1'b0);
    check({tag, "_we"}, PR3_RF_write_en, 1'b0);
    check({tag, "_mr"}, PR3_MEM_read, 1'b0);
    check({tag, "_mw"}, PR3_MEM_write, 1'b0);
    check({tag, "_res"}, PR3_alu_result, '0);
  endtask

  int  cyc, busy_n;
  bit  done, hold;

  initial begin
    #2;
    check_bubble("reset");
    check("reset_busy", ex_busy, 1'b0);
    settle();
    rst_n = 1'b1;
    run = 1'b1;

    instr(4'd0, 8'd5, 8'd3);
    tick(); settle();
    check("add_res", PR3_alu_result, 8'd8);
    check("add_zero", PR3_zero, 1'b0);
    check("add_valid", PR3_valid, 1'b1);

    instr(4'd0, 8'h0C, 8'h04);
    tick(); settle();
    instr(4'd1, 8'h77, 8'h66);
    forwardA = 2'd2; forwardB = 2'd1;
    PR4_wb_data = 8'h04;
    tick(); settle();
    check("sub_res", PR3_alu_result, 8'h0C);
    check("sub_store", PR3_store_data, 8'h04);

    instr(4'd0, 8'h30, 8'h11);
    PR2_alu_src = 1'b1; PR2_imm = 8'd2;
    PR2_RF_write_en = 1'b0; PR2_MEM_write = 1'b1;
    forwardB = 2'd1; PR4_wb_data = 8'hAA;
    tick(); settle();
    check("st_res", PR3_alu_result, 8'h32);
    check("st_data", PR3_store_data, 8'hAA);
    check("st_mw", PR3_MEM_write, 1'b1);

    instr(4'd1, 8'h09, 8'h09);
    tick(); settle();
    check("sub_zero", PR3_zero, 1'b1);

    instr(4'd7, 8'hFE, 8'h01);
    tick(); settle();
    check("slt_neg", PR3_alu_result, 8'd1);

    instr(4'd0, 8'd1, 8'd1);
    flush = 1'b1;
    tick(); settle();
    flush = 1'b0;
    check_bubble("flush");

    PR2_valid = 1'b0;
    tick(); settle();
    check_bubble("nop");

`ifdef MUL_EN
    instr(4'd9, 8'd7, 8'd6);
    cyc = 0; busy_n = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (ex_busy) busy_n++;
      tick(); settle(); cyc++;
      if (PR3_valid) done = 1'b1;
    end
    check("mul_busy_n", busy_n, 8);
    check("mul_edges", cyc, 9);
    check("mul_res", PR3_alu_result, 8'd42);
    PR2_valid = 1'b0; #1;
    check("mul_busy_end", ex_busy, 1'b0);

    instr(4'd9, 8'hFF, 8'h02);
    cyc = 0; done = 1'b0;
    for (int i = 0; i < 24 && !done; i++) begin
      if (cyc == 3) stall = 1'b1;
      if (cyc == 6) stall = 1'b0;
      tick(); settle(); cyc++;
      if (PR3_valid) done = 1'b1;
    end
    check("mul_st_edges", cyc, 12);
    check("mul_st_res", PR3_alu_result, 8'hFE);

    instr(4'd9, 8'd3, 8'd3);
    tick(); tick(); tick(); settle();
    flush = 1'b1; PR2_valid = 1'b0;
    tick(); settle();
    flush = 1'b0;
    check_bubble("mul_flush");
    check("mul_flush_busy", ex_busy, 1'b0);

    instr(4'd9, 8'd5, 8'd5);
    tick(); tick(); settle();
    PR2_valid = 1'b0;
    rst_n = 1'b0; #1;
    check_bubble("mul_rst");
    check("mul_rst_busy", ex_busy, 1'b0);
    settle();
    rst_n = 1'b1;
`else
    instr(4'd9, 8'd7, 8'd6);
    #1;
    check("nomul_busy", ex_busy, 1'b0);
    tick(); settle();
    check("nomul_res", PR3_alu_result, 8'd0);
    check("nomul_valid", PR3_valid, 1'b1);
`endif

    hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold) begin
        PR2_valid = ($urandom % 8) != 0;
        PR2_data_rs = W'($urandom);
        PR2_data_rt = W'($urandom);
        PR2_imm = W'($urandom);
        PR2_alu_src = $urandom % 2;
        PR2_alu_op = ($urandom % 4 == 0) ? 4'd9
                     : 4'($urandom_range(0, 15));
        PR2_rd = 3'($urandom);
        PR2_RF_write_en = $urandom % 2;
        PR2_MEM_read = $urandom % 2;
        PR2_MEM_write = $urandom % 2;
      end
      forwardA = 2'($urandom);
      forwardB = 2'($urandom);
      PR4_wb_data = W'($urandom);
      stall = ($urandom % 8) == 0;
      flush = ($urandom % 16) == 0;
      if (i == 1500) begin
        rst_n = 1'b0; #1;
        check_bubble("rnd_rst");
      end
      hold = exp_busy() || stall;
      tick(); settle();
      rst_n = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
